spi_avalon_master: RTL and testbench
====================================

SPI_AVALON_MASTER -- requirements
Module: spi_avalon_master

Interface
REQ-001 Parameter TX_ADDR, default 8'h00, Avalon address of the SPI slave write-data register.
REQ-002 Parameter RX_ADDR, default 8'h04, Avalon address of the SPI slave read-data register.
REQ-003 Parameter TIMEOUT_CYCLES, default 16'd4096, maximum clk cycles spent waiting for irq.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  / cmd_ready  out  1  / cmd_data  in  32: command word handshake from the local requester.
REQ-007 resp_valid  out  1  / resp_ready  in  1  / resp_data  out  32: SPI response word handshake to the local requester.
REQ-008 av_address  out  8 ; av_chip_select  out  1 ; av_write  out  1 ; av_read  out  1 ; av_write_data  out  32: Avalon-MM master outputs.
REQ-009 av_read_data  in  32 ; av_wait_request  in  1: Avalon-MM master inputs.
REQ-010 irq  in  1  level, high while the SPI slave holds an unread response.
REQ-011 busy  out  1  high in any state other than IDLE ; timeout_err  out  1  one-cycle error pulse.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, WRITE, WAIT_IRQ, READ and RESP.
REQ-013 IDLE: cmd_ready=1; a cmd_valid&&cmd_ready cycle latches cmd_data and moves to WRITE on the next edge.
REQ-014 WRITE: av_chip_select=1, av_write=1, av_address=TX_ADDR, av_write_data=latched word, all held stable until a cycle with av_wait_request=0, which completes the write and moves to WAIT_IRQ.
REQ-015 WAIT_IRQ: the 16-bit timeout counter clears on entry and increments every cycle; irq=1 moves to READ.
REQ-016 If the counter reaches TIMEOUT_CYCLES-1 with irq=0, the FSM SHALL return to IDLE, pulse timeout_err for exactly one cycle, and produce no response.
REQ-017 irq sampled outside WAIT_IRQ SHALL be ignored; an irq already high on entry to WAIT_IRQ moves to READ on the next edge (minimum one cycle in WAIT_IRQ).
REQ-018 READ: av_chip_select=1, av_read=1, av_address=RX_ADDR, held until av_wait_request=0; on that cycle av_read_data SHALL be captured into resp_data and the FSM moves to RESP.
REQ-019 RESP: resp_valid=1 and resp_data held stable until resp_ready=1; the handshake cycle returns the FSM to IDLE.
REQ-020 av_read and av_write SHALL never be high together; av_chip_select SHALL be high only in WRITE or READ.
REQ-021 Best-case latency from cmd handshake to resp_valid: 1 + write cycles + 1 + read cycles (4 cycles with av_wait_request=0 and irq already high).
REQ-022 Back-to-back operation: with resp_ready held high, the next command SHALL be accepted on the cycle after the RESP handshake.
REQ-023 cmd_ready SHALL be 0 in every state other than IDLE; commands are never queued.

Reset
REQ-024 Reset SHALL force state=IDLE, the counter and latched command word to 0, resp_data=0, cmd_ready=1, and resp_valid, busy, timeout_err and all av_* outputs to 0.
REQ-025 Reset asserted mid-transfer (any state) SHALL abort immediately and drop av_chip_select/av_read/av_write asynchronously, with no response emitted afterward.

Structure
REQ-026 Package spi_avalon_pkg SHALL hold the state enumeration and the default TX/RX address and timeout constants.
REQ-027 The timeout counter SHALL be one sub-module, spi_av_timer (clear, enable, terminal-count output); all other logic stays in the top module.

Verification
REQ-028 Verification SHALL cover cmd 32'hA5A5_0001, av_wait_request=0, irq high on entry, av_read_data=32'h1234_5678 -> resp_data=32'h1234_5678, resp_valid exactly 4 cycles after the cmd handshake.
REQ-029 Verification SHALL cover av_wait_request held high 3 cycles in WRITE -> av_write_data and av_address stay constant for 4 cycles, then WAIT_IRQ.
REQ-030 Verification SHALL cover irq never asserted, TIMEOUT_CYCLES=16 -> timeout_err single pulse, no resp_valid, cmd_ready=1 the cycle after the pulse.
REQ-031 Verification SHALL cover resp_ready low for 5 cycles -> resp_valid and resp_data stable throughout; with two queued cmds 32'h1 and 32'h2 and resp_ready high, the second handshake occurs the cycle after the first response.
REQ-032 Verification SHALL cover reset pulsed during READ with av_wait_request high -> all av_* outputs 0 during reset, no resp_valid, and a following cmd completes normally.

Source files
------------

// File: rtl/spi_avalon_pkg.sv
// Shared types and defaults for the SPI-over-Avalon command master.
package spi_avalon_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, WAIT_IRQ, READ, RESP} state_t;

  localparam logic [7:0]  DEF_TX_ADDR = 8'h00;
  localparam logic [7:0]  DEF_RX_ADDR = 8'h04;
  localparam logic [15:0] DEF_TIMEOUT = 16'd4096;
endpackage

// File: rtl/spi_avalon_master_if.sv
// Requester handshakes, Avalon-MM master bus and status lines of the SPI master.
interface spi_avalon_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [7:0]  av_address;
  logic        av_chip_select;
  logic        av_write;
  logic        av_read;
  logic [31:0] av_write_data;
  logic [31:0] av_read_data;
  logic        av_wait_request;
  logic        irq;
  logic        busy;
  logic        timeout_err;

  modport master (
    input  cmd_valid, cmd_data, resp_ready, av_read_data, av_wait_request, irq,
    output cmd_ready, resp_valid, resp_data, av_address, av_chip_select,
           av_write, av_read, av_write_data, busy, timeout_err
  );

  modport slave (
    output cmd_valid, cmd_data, resp_ready, av_read_data, av_wait_request, irq,
    input  cmd_ready, resp_valid, resp_data, av_address, av_chip_select,
           av_write, av_read, av_write_data, busy, timeout_err
  );
endinterface

// File: rtl/spi_av_timer.sv
// 16-bit irq-wait counter; terminal count flags the last allowed wait cycle.
module spi_av_timer #(
  parameter logic [15:0] TC_VAL = 16'd4096
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);
  logic [15:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_cnt <= '0;
    else if (i_clear)  r_cnt <= '0;
    else if (i_enable) r_cnt <= r_cnt + 16'd1;
  end

  assign o_tc = (r_cnt == TC_VAL - 16'd1);
endmodule

// File: rtl/spi_avalon_master.sv
// Command word -> Avalon write to the SPI slave, wait for irq, read back the response.
module spi_avalon_master
  import spi_avalon_pkg::*;
#(
  parameter logic [7:0]  TX_ADDR        = DEF_TX_ADDR,
  parameter logic [7:0]  RX_ADDR        = DEF_RX_ADDR,
  parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  spi_avalon_master_if.master bus
);
  state_t      r_state;
  logic [31:0] r_cmd;
  logic [31:0] r_resp_data;
  logic [7:0]  r_av_addr;
  logic        r_cmd_ready, r_resp_valid, r_busy, r_tmo;
  logic        r_av_cs, r_av_wr, r_av_rd;
  logic        w_tmr_clr, w_tmr_en, w_tc;

  // Counter is cleared on the write-completing edge so WAIT_IRQ starts at 0.
  assign w_tmr_clr = (r_state == WRITE) && !bus.av_wait_request;
  assign w_tmr_en  = (r_state == WAIT_IRQ);

  spi_av_timer #(.TC_VAL(TIMEOUT_CYCLES)) u_timer (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_clear  (w_tmr_clr),
    .i_enable (w_tmr_en),
    .o_tc     (w_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cmd        <= '0;
      r_resp_data  <= '0;
      r_av_addr    <= '0;
      r_cmd_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_tmo        <= 1'b0;
      r_av_cs      <= 1'b0;
      r_av_wr      <= 1'b0;
      r_av_rd      <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      case (r_state)
        IDLE: if (bus.cmd_valid && r_cmd_ready) begin
          r_cmd       <= bus.cmd_data;
          r_cmd_ready <= 1'b0;
          r_busy      <= 1'b1;
          r_av_cs     <= 1'b1;
          r_av_wr     <= 1'b1;
          r_av_addr   <= TX_ADDR;
          r_state     <= WRITE;
        end
        WRITE: if (!bus.av_wait_request) begin
          r_av_cs   <= 1'b0;
          r_av_wr   <= 1'b0;
          r_av_addr <= '0;
          r_state   <= WAIT_IRQ;
        end
        // irq wins over a coincident terminal count.
        WAIT_IRQ: if (bus.irq) begin
          r_av_cs   <= 1'b1;
          r_av_rd   <= 1'b1;
          r_av_addr <= RX_ADDR;
          r_state   <= READ;
        end else if (w_tc) begin
          r_tmo       <= 1'b1;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
        READ: if (!bus.av_wait_request) begin
          r_resp_data  <= bus.av_read_data;
          r_resp_valid <= 1'b1;
          r_av_cs      <= 1'b0;
          r_av_rd      <= 1'b0;
          r_av_addr    <= '0;
          r_state      <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_cmd_ready  <= 1'b1;
          r_state      <= IDLE;
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_cmd_ready  <= 1'b1;
          r_av_cs      <= 1'b0;
          r_av_wr      <= 1'b0;
          r_av_rd      <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready      = r_cmd_ready;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_data      = r_resp_data;
  assign bus.av_address     = r_av_addr;
  assign bus.av_chip_select = r_av_cs;
  assign bus.av_write       = r_av_wr;
  assign bus.av_read        = r_av_rd;
  assign bus.av_write_data  = r_cmd;
  assign bus.busy           = r_busy;
  assign bus.timeout_err    = r_tmo;
endmodule

// File: tb/tb_spi_avalon_master.sv
// Directed bench for spi_avalon_master: latency, wait states, timeout, backpressure, reset abort.
module tb_spi_avalon_master;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  spi_avalon_master_if bus();

  spi_avalon_master #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.resp_ready = 1'b0;
    bus.av_read_data = '0; bus.av_wait_request = 1'b0; bus.irq = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tmo", bus.timeout_err, 0);
    chk("rst_cs", bus.av_chip_select, 0);
    chk("rst_wr", bus.av_write, 0);
    chk("rst_rd", bus.av_read, 0);
    chk("rst_addr", bus.av_address, 0);
    chk("rst_wdata", bus.av_write_data, 0);
    chk("rst_rdata", bus.resp_data, 0);
    reset = 1'b0;
    tick();

    // best-case latency: irq already high, no wait states
    bus.irq = 1'b1; bus.av_read_data = 32'h1234_5678;
    bus.cmd_data = 32'hA5A5_0001; bus.cmd_valid = 1'b1;
    tick(); bus.cmd_valid = 1'b0;
    chk("t1_wr_cs", bus.av_chip_select, 1);
    chk("t1_wr", bus.av_write, 1);
    chk("t1_wr_rd", bus.av_read, 0);
    chk("t1_wr_addr", bus.av_address, 32'h00);
    chk("t1_wdata", bus.av_write_data, 32'hA5A5_0001);
    chk("t1_cmd_ready_busy", bus.cmd_ready, 0);
    chk("t1_busy", bus.busy, 1);
    chk("t1_rv_c1", bus.resp_valid, 0);
    tick();
    chk("t1_rv_c2", bus.resp_valid, 0);
    chk("t1_wait_cs", bus.av_chip_select, 0);
    tick();
    chk("t1_rd", bus.av_read, 1);
    chk("t1_rd_wr", bus.av_write, 0);
    chk("t1_rd_addr", bus.av_address, 32'h04);
    chk("t1_rv_c3", bus.resp_valid, 0);
    tick();
    chk("t1_rv_c4", bus.resp_valid, 1);
    chk("t1_rdata", bus.resp_data, 32'h1234_5678);
    chk("t1_resp_cs", bus.av_chip_select, 0);
    bus.resp_ready = 1'b1;
    tick(); bus.resp_ready = 1'b0;
    chk("t1_rv_done", bus.resp_valid, 0);
    chk("t1_ready_done", bus.cmd_ready, 1);
    chk("t1_busy_done", bus.busy, 0);

    // write held off by 3 wait-request cycles
    bus.irq = 1'b0; bus.av_wait_request = 1'b1;
    bus.cmd_data = 32'hCAFE_0002; bus.cmd_valid = 1'b1;
    tick(); bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_wr_hold", bus.av_write, 1);
      chk("t2_wdata_hold", bus.av_write_data, 32'hCAFE_0002);
      chk("t2_addr_hold", bus.av_address, 32'h00);
      if (i == 3) bus.av_wait_request = 1'b0;
      tick();
    end
    chk("t2_wait_wr", bus.av_write, 0);
    chk("t2_wait_cs", bus.av_chip_select, 0);
    chk("t2_wait_busy", bus.busy, 1);
    bus.irq = 1'b1; bus.av_read_data = 32'h0BAD_F00D;
    tick();
    chk("t2_rd", bus.av_read, 1);
    tick();
    chk("t2_rv", bus.resp_valid, 1);
    chk("t2_rdata", bus.resp_data, 32'h0BAD_F00D);
    bus.resp_ready = 1'b1;
    tick(); bus.resp_ready = 1'b0;

    // irq never arrives: 16 cycles in WAIT_IRQ then a single timeout pulse
    bus.irq = 1'b0;
    bus.cmd_data = 32'h0000_0003; bus.cmd_valid = 1'b1;
    tick(); bus.cmd_valid = 1'b0;
    tick();
    chk("t3_wait_busy", bus.busy, 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t3_no_early_tmo", bus.timeout_err, 0);
    end
    tick();
    chk("t3_tmo", bus.timeout_err, 1);
    chk("t3_tmo_rv", bus.resp_valid, 0);
    chk("t3_tmo_busy", bus.busy, 0);
    chk("t3_tmo_rd", bus.av_read, 0);
    tick();
    chk("t3_tmo_single", bus.timeout_err, 0);
    chk("t3_ready_after", bus.cmd_ready, 1);
    chk("t3_rv_after", bus.resp_valid, 0);

    // response backpressure, then back-to-back command
    bus.irq = 1'b1; bus.av_read_data = 32'h1111_0001;
    bus.cmd_data = 32'h0000_0001; bus.cmd_valid = 1'b1;
    tick(); bus.cmd_valid = 1'b0;
    tick(); tick(); tick();
    chk("t4_rv", bus.resp_valid, 1);
    bus.av_read_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_rv", bus.resp_valid, 1);
      chk("t4_hold_data", bus.resp_data, 32'h1111_0001);
      chk("t4_hold_no_ready", bus.cmd_ready, 0);
      tick();
    end
    bus.cmd_data = 32'h0000_0002; bus.cmd_valid = 1'b1; bus.resp_ready = 1'b1;
    tick();
    chk("t4_rv_drop", bus.resp_valid, 0);
    chk("t4_ready_next", bus.cmd_ready, 1);
    tick(); bus.cmd_valid = 1'b0;
    chk("t4_wr2", bus.av_write, 1);
    chk("t4_wdata2", bus.av_write_data, 32'h0000_0002);
    bus.av_read_data = 32'h2222_0002;
    tick(); tick(); tick();
    chk("t4_rv2", bus.resp_valid, 1);
    chk("t4_rdata2", bus.resp_data, 32'h2222_0002);
    tick(); bus.resp_ready = 1'b0;
    chk("t4_rv2_done", bus.resp_valid, 0);

    // reset during a stalled read aborts the transfer
    bus.cmd_data = 32'h0000_0005; bus.cmd_valid = 1'b1;
    tick(); bus.cmd_valid = 1'b0;
    tick();
    bus.av_wait_request = 1'b1;
    tick();
    chk("t5_rd", bus.av_read, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_cs", bus.av_chip_select, 0);
    chk("t5_async_rd", bus.av_read, 0);
    chk("t5_async_wr", bus.av_write, 0);
    chk("t5_async_addr", bus.av_address, 0);
    chk("t5_async_wdata", bus.av_write_data, 0);
    chk("t5_async_rv", bus.resp_valid, 0);
    chk("t5_async_ready", bus.cmd_ready, 1);
    tick();
    chk("t5_rst_cs", bus.av_chip_select, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_rv", bus.resp_valid, 0);
      chk("t5_idle_cs", bus.av_chip_select, 0);
    end
    bus.av_wait_request = 1'b0; bus.av_read_data = 32'h6666_0006;
    bus.cmd_data = 32'h0000_0006; bus.cmd_valid = 1'b1;
    tick(); bus.cmd_valid = 1'b0;
    chk("t5_wdata", bus.av_write_data, 32'h0000_0006);
    tick(); tick(); tick();
    chk("t5_rv", bus.resp_valid, 1);
    chk("t5_rdata", bus.resp_data, 32'h6666_0006);
    bus.resp_ready = 1'b1;
    tick(); bus.resp_ready = 1'b0;
    chk("t5_done_ready", bus.cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
